// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package div_sched_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr+1 modulo N.
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_vld
);

    int idx;

    // First requester after the last winner gets the one-hot grant.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider.sv
// Shared combinational unsigned divider; a zero divisor yields zero outputs.
module divider
    import div_sched_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    // Pure combinational divide; treated as a multicycle path by the scheduler.
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (divisor != '0) begin
            quotient  = dividend / divisor;
            remainder = dividend % divisor;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one multicycle divider among N requesters.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N       = 2,
    parameter int LATENCY = 4,
    localparam int IDW    = id_width(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N*DATA_W-1:0] req_a,
    input  logic [N*DATA_W-1:0] req_b,
    input  logic [N-1:0]        req_is_div,
    input  logic [N-1:0]        req_is_mod,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_dz,
    output logic                busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]      ptr_q, ptr_d;

    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                op_div_q, op_div_d;
    logic                op_mod_q, op_mod_d;
    logic [IDW-1:0]      op_id_q, op_id_d;

    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_dz_q, rsp_dz_d;

    logic [N-1:0]        gnt;
    logic [IDW-1:0]      gnt_idx;
    logic                gnt_vld;
    logic [DATA_W-1:0]   quot, rem;

    // Quotient wins over remainder; no flag selects zero.
    function automatic logic [DATA_W-1:0] sel_result(
        input logic              is_div,
        input logic              is_mod,
        input logic [DATA_W-1:0] q,
        input logic [DATA_W-1:0] r
    );
        if (is_div) return q;
        if (is_mod) return r;
        return '0;
    endfunction

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Divider sees only the registered operands, so its inputs stay stable while busy.
    divider u_divider (
        .dividend  (op_a_q),
        .divisor   (op_b_q),
        .quotient  (quot),
        .remainder (rem)
    );

    // Next-state, operand capture and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_div_d     = op_div_q;
        op_mod_d     = op_mod_q;
        op_id_d      = op_id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_dz_d     = rsp_dz_q;
        req_ready    = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = gnt;
                if (gnt_vld) begin
                    op_a_d   = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
                    op_b_d   = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
                    op_div_d = req_is_div[gnt_idx];
                    op_mod_d = req_is_mod[gnt_idx];
                    op_id_d  = gnt_idx;
                    ptr_d    = gnt_idx;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    rsp_id_d     = op_id_q;
                    rsp_result_d = sel_result(op_div_q, op_mod_q, quot, rem);
                    rsp_dz_d     = (op_b_q == '0);
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ptr_q        <= IDW'(N - 1);
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_dz_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_dz_q     <= rsp_dz_d;
        end
    end

    // Operand registers carry data only; they are always rewritten before use.
    always_ff @(posedge clk) begin
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
        op_div_q <= op_div_d;
        op_mod_q <= op_mod_d;
        op_id_q  <= op_id_d;
    end

    assign rsp_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_dz     = rsp_dz_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed plus randomized bench for div_sched against a behavioural model.
module tb_div_sched;

    localparam int N   = 2;
    localparam int LAT = 4;
    localparam int IDW = (N <= 2) ? 1 : $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_is_div;
    logic [N-1:0]    req_is_mod;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_dz;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ta [N];
    logic [31:0] tb [N];
    bit          tdiv [N];
    bit          tmod [N];
    int          exp_ptr;

    div_sched #(.N(N), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_is_div (req_is_div),
        .req_is_mod (req_is_mod),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_dz     (rsp_dz),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input bit d, input bit m);
        if (b == 0) return 32'd0;
        if (d) return a / b;
        if (m) return a % b;
        return 32'd0;
    endfunction

    function automatic int ref_grant(input logic [N-1:0] mask, input int ptr);
        for (int off = 1; off <= N; off++) begin
            if (mask[(ptr + off) % N]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = ta[i];
            req_b[i*32 +: 32] = tb[i];
            req_is_div[i]     = tdiv[i];
            req_is_mod[i]     = tmod[i];
        end
    endtask

    // One full transaction: grant, latency, optional backpressure, handshake.
    task automatic serve(input logic [N-1:0] mask, input int bp, input bit keep);
        int          g;
        int          waitc;
        logic [N-1:0] oh;
        logic [31:0] er;
        bit          edz;
        drive_ops();
        req_valid = mask;
        g = ref_grant(mask, exp_ptr);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        waitc = 0;
        @(negedge clk);
        while (req_ready == '0 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("ready_onehot", {31'd0, $countones(req_ready) == 1}, 32'd1);
        chk("grant", 32'(req_ready), 32'(oh));
        if (req_ready == '0 || g < 0) return;
        er  = ref_result(ta[g], tb[g], tdiv[g], tmod[g]);
        edz = (tb[g] == 0);
        @(posedge clk);
        exp_ptr = g;
        #1;
        if (!keep) begin
            req_valid[g] = 1'b0;
            ta[g] = $urandom;
            tb[g] = $urandom;
            tdiv[g] = 1'($urandom);
            tmod[g] = 1'($urandom);
            drive_ops();
        end
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("ready_after_accept", 32'(req_ready), 32'd0);
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk);
            #1;
            chk("rsp_valid_latency", {31'd0, rsp_valid}, (i == LAT) ? 32'd1 : 32'd0);
        end
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_result", rsp_result, er);
        chk("rsp_dz", {31'd0, rsp_dz}, {31'd0, edz});
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, er);
            chk("bp_id", 32'(rsp_id), 32'(g));
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
        chk("busy_after_handshake", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] m;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            ta[i] = 0; tb[i] = 1; tdiv[i] = 0; tmod[i] = 0;
        end
        drive_ops();
        exp_ptr = N - 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_id", 32'(rsp_id), 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_dz", {31'd0, rsp_dz}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Contention from reset: both requesters valid throughout, order 0,1,0,1.
        ta[0] = 1000; tb[0] = 10; tdiv[0] = 1; tmod[0] = 0;
        ta[1] = 1001; tb[1] = 10; tdiv[1] = 0; tmod[1] = 1;
        drive_ops();
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) serve(2'b11, 0, 1'b1);
        req_valid = '0;

        // Single divide: 100/7 = 14 from requester 0.
        ta[0] = 100; tb[0] = 7; tdiv[0] = 1; tmod[0] = 0;
        serve(2'b01, 0, 1'b0);
        // Remainder from requester 1: 100%7 = 2.
        ta[1] = 100; tb[1] = 7; tdiv[1] = 0; tmod[1] = 1;
        serve(2'b10, 0, 1'b0);
        // Divide by zero.
        ta[0] = 5; tb[0] = 0; tdiv[0] = 1; tmod[0] = 0;
        serve(2'b01, 0, 1'b0);
        // Backpressure for 10 cycles.
        ta[1] = 12345; tb[1] = 11; tdiv[1] = 1; tmod[1] = 0;
        serve(2'b10, 10, 1'b0);
        // Precedence: both flags, then no flags.
        ta[0] = 32'hFFFF_FFFF; tb[0] = 16; tdiv[0] = 1; tmod[0] = 1;
        serve(2'b01, 0, 1'b0);
        ta[1] = 77; tb[1] = 5; tdiv[1] = 0; tmod[1] = 0;
        serve(2'b10, 0, 1'b0);

        // Reset two cycles after an accept: no response, pointer restored.
        ta[1] = 99; tb[1] = 3; tdiv[1] = 1; tmod[1] = 0;
        drive_ops();
        req_valid = 2'b10;
        @(negedge clk);
        chk("mid_reset_grant", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ptr = N - 1;
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_result", rsp_result, 32'd0);
        for (int k = 0; k < LAT + 4; k++) begin
            @(posedge clk);
            #1;
            chk("no_rsp_after_reset", {31'd0, rsp_valid}, 32'd0);
        end
        ta[0] = 64; tb[0] = 8; tdiv[0] = 1; tmod[0] = 0;
        ta[1] = 65; tb[1] = 8; tdiv[1] = 0; tmod[1] = 1;
        serve(2'b11, 0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) begin
                ta[i]   = $urandom;
                tb[i]   = ($urandom_range(0, 5) == 0) ? 32'd0 :
                          (($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom);
                tdiv[i] = 1'($urandom);
                tmod[i] = 1'($urandom);
            end
            do m = N'($urandom); while (m == '0);
            serve(m, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
